// File: rtl/serial_feeder_pkg.sv
// serial_feeder_pkg: shared types and constants for the serial bit feeder.
// Optional feature macro used by the feeder top: SERIAL_FEEDER_PAUSE_EN.
package serial_feeder_pkg;

    localparam int FEEDER_DEFAULT_WIDTH = 20;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/serial_feeder_cnt.sv
// serial_feeder_cnt: modulo-WIDTH bit counter for the feeder.
// clr has priority over en; term flags the final bit position (WIDTH-1).
module serial_feeder_cnt
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH = FEEDER_DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt;

    assign term = (cnt == LAST_VAL);

    // Count advancing bits, wrapping to 0 after the last position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= term ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: accepts a WIDTH-bit word and sends it LSB-first on x,
// one bit per clock, streaming consecutive words with no idle gap.
// Optional macro SERIAL_FEEDER_PAUSE_EN adds a pause input that freezes shifting.
//
// Handshake: a word transfers on a rising edge where load_valid and
// load_ready are both high. load_ready depends only on registered state
// (and pause when enabled), never on load_valid. A source that sees
// load_ready low must hold load_valid and load_data steady until accepted.
module serial_bit_feeder
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH = FEEDER_DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
`ifdef SERIAL_FEEDER_PAUSE_EN
    input  logic             pause,
`endif
    output logic             load_ready,
    output logic             x,
    output logic             x_valid,
    output logic             done,
    output logic             busy
);

    feeder_state_t    state;
    logic [WIDTH-1:0] shreg;
    logic             paused;
    logic             advance;
    logic             last;
    logic             term;
    logic             transfer;

`ifdef SERIAL_FEEDER_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    assign advance    = (state == SHIFT) && !paused;
    assign last       = advance && term;
    assign load_ready = (state == IDLE) || last;
    assign transfer   = load_valid && load_ready;

    assign x       = shreg[0];
    assign x_valid = advance;
    assign done    = last;
    assign busy    = (state == SHIFT);

    // A fresh word always restarts the count; otherwise the counter wraps
    // to 0 by itself on the last bit.
    serial_feeder_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (transfer),
        .en   (advance),
        .term (term)
    );

    // State and shift register: load on transfer, drain to IDLE after the
    // last bit, otherwise shift right with zero fill while advancing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
        end else if (transfer) begin
            state <= SHIFT;
            shreg <= load_data;
        end else if (last) begin
            state <= IDLE;
            shreg <= '0;
        end else if (advance) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: table-driven check of serial_bit_feeder (WIDTH=20),
// with hand-written sequences for reset mid-word and detector integration.
// Define SERIAL_FEEDER_PAUSE_EN for both RTL and bench to exercise pause.
module tb_serial_bit_feeder;

    localparam int W = 20;
    // Output vector order: {x, x_valid, done, load_ready, busy}
    localparam logic [4:0] IDLE_V = 5'b00010;

    typedef struct {
        logic         lv;
        logic [W-1:0] ld;
        logic         pz;
        logic [4:0]   exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] load_data = '0;
    logic         load_valid = 1'b0;
`ifdef SERIAL_FEEDER_PAUSE_EN
    logic         pause = 1'b0;
`endif
    logic         load_ready;
    logic         x;
    logic         x_valid;
    logic         done;
    logic         busy;
    logic [4:0]   outs;

    vec_t         tbl[$];
    logic [4:0]   exp_q[$];
    int           total = 0;
    int           bad = 0;

    assign outs = {x, x_valid, done, load_ready, busy};

    serial_bit_feeder #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_data  (load_data),
        .load_valid (load_valid),
`ifdef SERIAL_FEEDER_PAUSE_EN
        .pause      (pause),
`endif
        .load_ready (load_ready),
        .x          (x),
        .x_valid    (x_valid),
        .done       (done),
        .busy       (busy)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic lv, input logic [W-1:0] ld, input logic pz,
                       input logic [4:0] e);
        vec_t v;
        v.lv = lv; v.ld = ld; v.pz = pz; v.exp = e;
        tbl.push_back(v);
    endtask

    // Each record describes one cycle: inputs driven after the falling edge,
    // outputs compared 1 time unit later, before the next rising edge.
    task automatic run_tbl(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            load_valid = tbl[i].lv;
            load_data  = tbl[i].ld;
`ifdef SERIAL_FEEDER_PAUSE_EN
            pause      = tbl[i].pz;
`endif
            #1;
            check(name, i, 32'(outs), 32'(tbl[i].exp));
        end
        tbl.delete();
    endtask

    int           sw_bits[W] = '{0,0,1,0,1,1,1,0,1,1,0,1,0,1,1,1,0,1,1,1};
    logic [W-1:0] wa;
    logic [W-1:0] wb;
    logic [4:0]   win;
    int           fill;
    int           bidx;
    int           done_seen;

    initial begin
        // Reset
        #2 rst = 1'b0;
        #1 check("reset", 0, 32'(outs), 32'(IDLE_V));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Single word, hand-listed bit order
        add(1'b1, 20'b11101110101101110100, 1'b0, IDLE_V);
        for (int i = 0; i < W; i++)
            add(1'b0, '0, 1'b0, {1'(sw_bits[i]), 1'b1, i == W-1, i == W-1, 1'b1});
        add(1'b0, '0, 1'b0, IDLE_V);
        run_tbl("single");

        // Back-to-back: all ones then all zeros, no gap
        add(1'b1, 20'hFFFFF, 1'b0, IDLE_V);
        for (int i = 0; i < W; i++)
            add(1'b1, 20'h00000, 1'b0, {1'b1, 1'b1, i == W-1, i == W-1, 1'b1});
        for (int i = 0; i < W; i++)
            add(1'b0, '0, 1'b0, {1'b0, 1'b1, i == W-1, i == W-1, 1'b1});
        add(1'b0, '0, 1'b0, IDLE_V);
        run_tbl("b2b");

        // Load offered at bit 5 is held off until the last bit
        wa = 20'hF0F0F;
        wb = 20'h12345;
        add(1'b1, wa, 1'b0, IDLE_V);
        for (int i = 0; i < W; i++)
            add(i >= 5, (i >= 5) ? wb : '0, 1'b0, {wa[i], 1'b1, i == W-1, i == W-1, 1'b1});
        for (int i = 0; i < W; i++)
            add(1'b0, '0, 1'b0, {wb[i], 1'b1, i == W-1, i == W-1, 1'b1});
        add(1'b0, '0, 1'b0, IDLE_V);
        run_tbl("busy_ign");

`ifdef SERIAL_FEEDER_PAUSE_EN
        // Pause 3 cycles at bit 4; done lands 23 cycles after accept
        wa = 20'hAAAAA;
        add(1'b1, wa, 1'b0, IDLE_V);
        for (int i = 0; i < 4; i++)
            add(1'b0, '0, 1'b0, {wa[i], 1'b1, 1'b0, 1'b0, 1'b1});
        for (int i = 0; i < 3; i++)
            add(1'b0, '0, 1'b1, {wa[4], 1'b0, 1'b0, 1'b0, 1'b1});
        for (int i = 4; i < W; i++)
            add(1'b0, '0, 1'b0, {wa[i], 1'b1, i == W-1, i == W-1, 1'b1});
        add(1'b0, '0, 1'b0, IDLE_V);
        add(1'b0, '0, 1'b1, IDLE_V);
        run_tbl("pause");
`endif

        // Reset mid-word at bit 7
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 20'hFFFFF;
        #1 check("rst_accept", 0, 32'(outs), 32'(IDLE_V));
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            #1;
            if (i == 7) check("rst_pre", i, 32'(outs), 32'(5'b11001));
        end
        rst = 1'b0;
        #1 check("rst_async", 0, 32'(outs), 32'(IDLE_V));
        done_seen = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            #1;
            if (done || x_valid) done_seen++;
        end
        check("rst_nodone", 0, 32'(done_seen), 32'd0);
        check("rst_idle", 0, 32'(outs), 32'(IDLE_V));

        // Detector integration: non-overlapping 11011 over the stream
        exp_q.push_back(5'd9);
        exp_q.push_back(5'd18);
        win  = '0;
        fill = 0;
        bidx = 0;
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 20'b11101110101101110100;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            #1;
            if (x_valid) begin
                win = {win[3:0], x};
                fill++;
                if (fill >= 5 && win == 5'b11011) begin
                    if (exp_q.size() == 0) check("det_extra", bidx, 32'(bidx), 32'hFFFF);
                    else check("det_idx", bidx, 32'(bidx), 32'(exp_q.pop_front()));
                    win  = '0;
                    fill = 0;
                end
                bidx++;
            end
        end
        check("det_bits", 0, 32'(bidx), 32'(W));
        check("det_left", 0, 32'(exp_q.size()), 32'd0);

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
